// File: rtl/ovp_gen_pkg.sv
// Shared types and default timing for the output vertical-pulse generator.
// Default timing assumes a 1024-clk sub-period.
package ovp_gen_pkg;

  typedef enum logic [1:0] {
    ST_INT,
    ST_WAIT_RX,
    ST_RX
  } src_state_e;

  localparam int QA_LEN_DEF = 1024;

  localparam int F59_QA_VTP = 550;
  localparam int F59_QB_VT  = 2036;
  localparam int F59_QB_OVR = 2092;

  localparam int F50_QA_VTP = 414;
  localparam int F50_QB_VT  = 2441;
  localparam int F50_QB_OVR = 2516;

endpackage

// File: rtl/ovp_tbase.sv
// Free-running two-level timebase (qa sub-period, qb period count)
// producing the internal VP and the over-VP timeout.
module ovp_tbase #(
  parameter int QA_W = 11,
  parameter int QB_W = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            restart,
  input  logic [QA_W-1:0] cfg_qa_len,
  input  logic [QA_W-1:0] cfg_qa_vtp,
  input  logic [QB_W-1:0] cfg_qb_vt,
  input  logic [QB_W-1:0] cfg_qb_ovr,
  output logic            int_vp,
  output logic            ovr
);

  logic [QA_W-1:0] qa;
  logic [QB_W-1:0] qb;
  logic            qa_end;
  logic            qa_short;

  assign qa_end   = (qa == cfg_qa_len);
  // Degenerate lengths pin qa at 1 instead of running off to wrap.
  assign qa_short = (cfg_qa_len <= QA_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      qa     <= QA_W'(1);
      qb     <= '0;
      int_vp <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      if (restart || qa_end || qa_short)
        qa <= QA_W'(1);
      else
        qa <= qa + QA_W'(1);
      if (restart)
        qb <= '0;
      else if (qa_end && (qb != '1))
        qb <= qb + QB_W'(1);
      int_vp <= (qa == cfg_qa_vtp) && (qb == cfg_qb_vt);
      ovr    <= qa_end && (qb == cfg_qb_ovr);
    end
  end

endmodule

// File: rtl/ovp_gen_c.sv
// Output VP generator: picks receiver or internal VP, decimates,
// and flags receiver loss via the over-VP timeout.
module ovp_gen_c
  import ovp_gen_pkg::*;
#(
  parameter int QA_W  = 11,
  parameter int QB_W  = 12,
  parameter int DEC_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_ok,
  input  logic             rx_vp,
  input  logic [QA_W-1:0]  cfg_qa_len,
  input  logic [QA_W-1:0]  cfg_qa_vtp,
  input  logic [QB_W-1:0]  cfg_qb_vt,
  input  logic [QB_W-1:0]  cfg_qb_ovr,
  input  logic [DEC_W-1:0] cfg_dec,
  output logic             ovp,
  output logic             frame_alt,
  output logic             adv_int_vp,
  output logic             rx_vp_sel,
  output logic             over_vp
);

  src_state_e       state;
  src_state_e       state_n;
  logic             rx_vp_d;
  logic             rx_edge;
  logic             int_vp;
  logic             ovr;
  logic             sel_vp;
  logic             pass;
  logic [DEC_W-1:0] qc;

  assign rx_edge    = rx_vp & ~rx_vp_d;
  assign adv_int_vp = int_vp;

  ovp_tbase #(
    .QA_W(QA_W),
    .QB_W(QB_W)
  ) u_tbase (
    .clk        (clk),
    .rst        (rst),
    .restart    (sel_vp | ovr),
    .cfg_qa_len (cfg_qa_len),
    .cfg_qa_vtp (cfg_qa_vtp),
    .cfg_qb_vt  (cfg_qb_vt),
    .cfg_qb_ovr (cfg_qb_ovr),
    .int_vp     (int_vp),
    .ovr        (ovr)
  );

  always_comb begin
    state_n = state;
    sel_vp  = int_vp;
    unique case (state)
      ST_INT: begin
        if (rx_ok) state_n = ST_WAIT_RX;
      end
      ST_WAIT_RX: begin
        if (!rx_ok) begin
          state_n = ST_INT;
        end else if (rx_edge) begin
          state_n = ST_RX;
          sel_vp  = 1'b1;
        end
      end
      ST_RX: begin
        sel_vp = rx_edge;
        if (!rx_ok) state_n = ST_INT;
      end
      default: state_n = ST_INT;
    endcase
  end

  assign pass = sel_vp && (qc == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INT;
      rx_vp_d   <= 1'b0;
      qc        <= '0;
      ovp       <= 1'b0;
      frame_alt <= 1'b0;
      rx_vp_sel <= 1'b0;
      over_vp   <= 1'b0;
    end else begin
      state   <= state_n;
      rx_vp_d <= rx_vp;
      // A source switch restarts the decimation phase.
      if (state_n != state)
        qc <= '0;
      else if (sel_vp)
        qc <= (qc >= cfg_dec) ? '0 : qc + DEC_W'(1);
      ovp       <= pass;
      frame_alt <= frame_alt ^ ovp;
      rx_vp_sel <= (state == ST_RX);
      over_vp   <= ovr;
    end
  end

endmodule

// File: tb/tb_ovp_gen_c.sv
// Scoreboard bench for ovp_gen_c: directed scenarios push expected
// pulse cycles; a negedge monitor pops and compares on each pulse.
module tb_ovp_gen_c;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_ok = 1'b0;
  logic        rx_vp = 1'b0;
  logic [10:0] cfg_qa_len = 11'd8;
  logic [10:0] cfg_qa_vtp = 11'd3;
  logic [11:0] cfg_qb_vt  = 12'd5;
  logic [11:0] cfg_qb_ovr = 12'd7;
  logic [1:0]  cfg_dec = 2'd0;
  logic        ovp;
  logic        frame_alt;
  logic        adv_int_vp;
  logic        rx_vp_sel;
  logic        over_vp;

  ovp_gen_c dut (
    .clk        (clk),
    .rst        (rst),
    .rx_ok      (rx_ok),
    .rx_vp      (rx_vp),
    .cfg_qa_len (cfg_qa_len),
    .cfg_qa_vtp (cfg_qa_vtp),
    .cfg_qb_vt  (cfg_qb_vt),
    .cfg_qb_ovr (cfg_qb_ovr),
    .cfg_dec    (cfg_dec),
    .ovp        (ovp),
    .frame_alt  (frame_alt),
    .adv_int_vp (adv_int_vp),
    .rx_vp_sel  (rx_vp_sel),
    .over_vp    (over_vp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   c;
    logic fa;
  } ev_t;

  ev_t q_ovp[$];
  int  q_ovr[$];
  int  tests = 0;
  int  fails = 0;

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               name, act, exp, cyc);
    end
  endfunction

  ev_t e;
  int  oc;

  always @(negedge clk) begin
    if (ovp) begin
      if (q_ovp.size() == 0) begin
        chk("ovp_unexpected", cyc, -1);
      end else begin
        e = q_ovp.pop_front();
        chk("ovp_cycle", cyc, e.c);
        chk("ovp_frame_alt", int'(frame_alt), int'(e.fa));
      end
    end
    if (over_vp) begin
      if (q_ovr.size() == 0) begin
        chk("over_vp_unexpected", cyc, -1);
      end else begin
        oc = q_ovr.pop_front();
        chk("over_vp_cycle", cyc, oc);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(int c);
    while (cyc < c) step(1);
  endtask

  function automatic ev_t mk(int c, logic fa);
    ev_t r;
    r.c  = c;
    r.fa = fa;
    return r;
  endfunction

  int n0, t, u, r;

  initial begin
    step(3);
    chk("rst_ovp", int'(ovp), 0);
    chk("rst_frame_alt", int'(frame_alt), 0);
    chk("rst_adv_int_vp", int'(adv_int_vp), 0);
    chk("rst_rx_vp_sel", int'(rx_vp_sel), 0);
    chk("rst_over_vp", int'(over_vp), 0);

    // free-run: int_vp every 44, ovp one later
    rst = 1'b0;
    n0  = cyc;
    q_ovp.push_back(mk(n0 + 44, 1'b0));
    q_ovp.push_back(mk(n0 + 88, 1'b1));
    q_ovp.push_back(mk(n0 + 132, 1'b0));
    step_to(n0 + 43);
    chk("fr_adv_int_vp", int'(adv_int_vp), 1);
    step(1);
    chk("fr_adv_int_vp_1clk", int'(adv_int_vp), 0);
    step_to(n0 + 140);

    // lock, then one 3-clk rx_vp
    t     = cyc;
    rx_ok = 1'b1;
    q_ovp.push_back(mk(t + 4, 1'b1));
    q_ovr.push_back(t + 69);
    q_ovr.push_back(t + 134);
    q_ovr.push_back(t + 199);
    step_to(t + 3);
    rx_vp = 1'b1;
    step(3);
    rx_vp = 1'b0;
    step_to(t + 10);
    chk("rx_vp_sel_locked", int'(rx_vp_sel), 1);

    // rx_vp stopped: only over_vp pulses
    step_to(t + 200);
    chk("rx_vp_sel_stopped", int'(rx_vp_sel), 1);

    // decimation by 3 over 9 edges
    u       = cyc;
    cfg_dec = 2'd2;
    q_ovp.push_back(mk(u + 3, 1'b0));
    q_ovp.push_back(mk(u + 33, 1'b1));
    q_ovp.push_back(mk(u + 63, 1'b0));
    for (int k = 0; k < 9; k++) begin
      step_to(u + 2 + 10 * k);
      rx_vp = 1'b1;
      step(1);
      rx_vp = 1'b0;
    end
    step_to(u + 84);
    chk("dec_frame_alt", int'(frame_alt), 1);

    // loss of lock: back to internal VP
    step_to(u + 85);
    cfg_dec = 2'd0;
    rx_ok   = 1'b0;
    q_ovp.push_back(mk(u + 127, 1'b1));
    step_to(u + 90);
    chk("rx_vp_sel_lost", int'(rx_vp_sel), 0);

    // reset right as a pulse is pending
    step_to(u + 170);
    chk("pre_rst_adv_int_vp", int'(adv_int_vp), 1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_ovp", int'(ovp), 0);
    chk("mid_rst_frame_alt", int'(frame_alt), 0);
    chk("mid_rst_adv_int_vp", int'(adv_int_vp), 0);
    chk("mid_rst_rx_vp_sel", int'(rx_vp_sel), 0);
    chk("mid_rst_over_vp", int'(over_vp), 0);
    step(1);
    rst = 1'b0;
    r   = cyc;
    q_ovp.push_back(mk(r + 44, 1'b0));
    step_to(r + 50);

    chk("ovp_queue_left", q_ovp.size(), 0);
    chk("over_vp_queue_left", q_ovr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ovp_gen_c.md
OVP_GEN_C -- requirements
Module: ovp_gen_c

Interface
REQ-001 Parameter QA_W, default 11, width of sub-period counter qa.
REQ-002 Parameter QB_W, default 12, width of sub-period count qb.
REQ-003 Parameter DEC_W, default 2, width of frame-decimation counter.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rx_ok  in  1  receiver lock; 1 = rx_vp usable.
REQ-007 rx_vp  in  1  receiver vertical pulse, any width.
REQ-008 cfg_qa_len  in  QA_W  sub-period length in clk (default timing 1024).
REQ-009 cfg_qa_vtp  in  QA_W  qa match point for internal VP.
REQ-010 cfg_qb_vt  in  QB_W  qb match point for internal VP.
REQ-011 cfg_qb_ovr  in  QB_W  qb match point for over-VP timeout.
REQ-012 cfg_dec  in  DEC_W  output every (cfg_dec+1)-th VP.
REQ-013 ovp  out  1  output vertical pulse, 1 clk.
REQ-014 frame_alt  out  1  toggles once per ovp.
REQ-015 adv_int_vp  out  1  internal VP, 1 clk, one cycle ahead of ovp.
REQ-016 rx_vp_sel  out  1  1 = receiver VP is the selected source.
REQ-017 over_vp  out  1  timeout pulse, 1 clk.

Function
REQ-018 Edge detect: rx_edge = rx_vp & ~rx_vp_d (registered copy); a multi-cycle rx_vp yields one event.
REQ-019 qa: reloads to 1 when ovp_a or qa == cfg_qa_len, else increments; cfg_qa_len <= 1 holds qa at 1.
REQ-020 qb: clears on ovp_a; else increments when qa == cfg_qa_len; saturates at all-ones, never wraps.
REQ-021 int_vp registered = (qa == cfg_qa_vtp) & (qb == cfg_qb_vt); adv_int_vp = int_vp.
REQ-022 ovr registered = (qa == cfg_qa_len) & (qb == cfg_qb_ovr); over_vp = ovr delayed 1 clk.
REQ-023 Source FSM states: INT, WAIT_RX, RX.
REQ-024 Transitions: INT->WAIT_RX when rx_ok; WAIT_RX->RX on rx_edge & rx_ok; WAIT_RX->INT and RX->INT when ~rx_ok.
REQ-025 sel_vp = rx_edge in RX or on the WAIT_RX->RX edge; otherwise sel_vp = int_vp. In WAIT_RX, int_vp still drives output.
REQ-026 rx_vp_sel = (state == RX), registered.
REQ-027 ovp_a = sel_vp | ovr restarts the timebase; ovr alone never produces ovp.
REQ-028 Decimation counter qc: cleared on rst or any FSM state change. On sel_vp, pass iff qc == 0; qc increments, wrapping to 0 after cfg_dec. cfg_dec = 0 passes every VP.
REQ-029 ovp = registered passed sel_vp; latency from rx_edge or int_vp to ovp is 1 clk.
REQ-030 frame_alt inverts the cycle after each ovp.
REQ-031 sel_vp and ovr in the same cycle produce a single restart; ovp and over_vp both still follow their own rules.
REQ-032 cfg_* are quasi-static; a change takes effect at the next compare and needs no flush.

Reset
REQ-033 On rst: ovp, frame_alt, adv_int_vp, rx_vp_sel, over_vp = 0; qa = 1; qb = 0; qc = 0; rx_vp_d = 0; state = INT.
REQ-034 rst mid-frame discards any pending pulse; free-run restarts from qa = 1 the cycle after rst deasserts.

Structure
REQ-035 Package ovp_gen_pkg holds the FSM state enum and default timing constants: F59 qa_vtp 550, qb_vt 2036, qb_ovr 2092; F50 qa_vtp 414, qb_vt 2441, qb_ovr 2516; qa_len 1024.
REQ-036 Sub-module ovp_tbase contains qa/qb, int_vp and ovr generation; ovp_gen_c holds the FSM, decimation and outputs.

Verification
REQ-037 Bench timing for all scenarios: cfg_qa_len = 8, cfg_qa_vtp = 3, cfg_qb_vt = 5, cfg_qb_ovr = 7.
REQ-038 Free-run (rx_ok = 0, cfg_dec = 0) -> adv_int_vp every 44 clk, ovp 1 clk later, frame_alt alternating, over_vp never.
REQ-039 RX with rx_vp stopped (rx_ok = 1) -> over_vp every 65 clk, ovp stays 0, rx_vp_sel = 1.
REQ-040 INT, rx_ok rises, 3-clk rx_vp -> exactly one 1-clk ovp; rx_vp_sel = 1 thereafter.
REQ-041 RX, cfg_dec = 2, 9 rx_vp edges -> ovp on edges 1, 4, 7 only; frame_alt toggles 3 times.
REQ-042 rx_ok drops in RX -> state INT; next ovp 45 clk after last sel_vp (44-clk int_vp period + 1-clk ovp latency); rst mid-frame -> all outputs 0 next clk.
